// File: rtl/inverter_pkg.sv
// Shared constants and helpers for the inverter_unit polarity-correction cell.
package inverter_pkg;

  localparam int unsigned PIPE_STAGES_MAX = 4;
  localparam int unsigned TOGGLE_CNT_W    = 16;

  // Saturating increment for the optional toggle counter.
  function automatic logic [TOGGLE_CNT_W-1:0] sat_inc(input logic [TOGGLE_CNT_W-1:0] v);
    return (v == {TOGGLE_CNT_W{1'b1}}) ? v : v + TOGGLE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/inverter_pipe_stage.sv
// One data+valid register of the q pipeline; data loads only when i_en is set.
module inverter_pipe_stage #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Valid advances every cycle; data holds when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_en) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/inverter_unit.sv
// Bit-wise inverter: combinational o = ~i plus a masked, valid-qualified q pipeline.
// Optional toggle counter on q enabled by INVERTER_UNIT_TOGGLE_CNT_EN.
module inverter_unit
  import inverter_pkg::*;
#(
  parameter int unsigned       DATA_W      = 1,
  parameter int unsigned       PIPE_STAGES = 1,
  parameter logic [DATA_W-1:0] MASK_RST    = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] o,
  input  logic              mask_wr,
  input  logic [DATA_W-1:0] mask_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
  ,
  output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

  typedef logic [DATA_W-1:0] data_t;

  // Out-of-range stage counts clamp into 1..PIPE_STAGES_MAX.
  localparam int unsigned N_STAGES =
    (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX :
    ((PIPE_STAGES < 1) ? 1 : PIPE_STAGES);

  data_t r_mask;
  data_t w_data  [N_STAGES+1];
  logic  w_valid [N_STAGES+1];

  // Pure 4-state inversion, independent of clock, reset and mask.
  assign o = ~i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_mask <= MASK_RST;
    else if (mask_wr) r_mask <= mask_in;
  end

  assign w_data[0]  = i ^ r_mask;
  assign w_valid[0] = in_valid;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic w_en;
    if (k == 0) begin : g_first
      assign w_en = in_valid;
    end else begin : g_rest
      assign w_en = 1'b1;
    end

    inverter_pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1])
    );
  end

  assign q       = w_data[N_STAGES];
  assign q_valid = w_valid[N_STAGES];

`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
  logic [TOGGLE_CNT_W-1:0] r_toggle_cnt;
  data_t                   r_prev_q;
  logic                    r_have_prev;

  // Counts changes between consecutive valid q words; the first valid only seeds r_prev_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toggle_cnt <= '0;
      r_prev_q     <= '0;
      r_have_prev  <= 1'b0;
    end else if (q_valid) begin
      if (r_have_prev && (q != r_prev_q)) r_toggle_cnt <= sat_inc(r_toggle_cnt);
      r_prev_q    <= q;
      r_have_prev <= 1'b1;
    end
  end

  assign toggle_cnt = r_toggle_cnt;
`endif

endmodule

// File: tb/tb_inverter_unit.sv
// Directed self-checking bench for inverter_unit: a 1-bit combinational instance
// and an 8-bit, 2-stage instance exercising the masked q pipeline.
`timescale 1ns/1ps
module tb_inverter_unit;

  logic clk;
  logic rst;

  // 1-bit instance for the 4-state combinational path
  logic i1;
  logic o1;
  logic q1;
  logic qv1;

  // 8-bit, two-stage instance for the registered path
  logic [7:0] i8;
  logic [7:0] o8;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       in_valid;
  logic [7:0] q8;
  logic       qv8;
`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
  logic [15:0] tc1;
  logic [15:0] tc8;
`endif

  int n_checks = 0;
  int n_errors = 0;

  inverter_unit #(.DATA_W(1), .PIPE_STAGES(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .i        (i1),
    .o        (o1),
    .mask_wr  (1'b0),
    .mask_in  (1'b0),
    .in_valid (1'b0),
    .q        (q1),
    .q_valid  (qv1)
`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
    ,
    .toggle_cnt (tc1)
`endif
  );

  inverter_unit #(.DATA_W(8), .PIPE_STAGES(2), .MASK_RST(8'hFF)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .i        (i8),
    .o        (o8),
    .mask_wr  (mask_wr),
    .mask_in  (mask_in),
    .in_valid (in_valid),
    .q        (q8),
    .q_valid  (qv8)
`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
    ,
    .toggle_cnt (tc8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference 4-state NOT for one bit: 0->1, 1->0, X/Z->X.
  function automatic logic not4(input logic b);
    if (b === 1'b0) return 1'b1;
    if (b === 1'b1) return 1'b0;
    return 1'bx;
  endfunction

  // Advance one rising edge; inputs set after this return are sampled on the next edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    i1       = 1'b0;
    i8       = 8'h00;
    mask_wr  = 1'b0;
    mask_in  = 8'h00;
    in_valid = 1'b0;

    // Combinational truth table, checked 10 ns after each change
    i1 = 1'b0; #10; check_eq("comb_i0", 16'(o1), 16'(1'b1));
    i1 = 1'b1; #10; check_eq("comb_i1", 16'(o1), 16'(1'b0));
    i1 = 1'bx; #10; check_eq("comb_iX", 16'(o1), 16'(not4(i1)));
    i1 = 1'bz; #10; check_eq("comb_iZ", 16'(o1), 16'(not4(i1)));

    // Reset state with o still live
    i8 = 8'hA5; #1;
    check_eq("rst_q",      16'(q8),  16'h0000);
    check_eq("rst_qvalid", 16'(qv8), 16'h0000);
    check_eq("rst_o8",     16'(o8),  16'h005A);

    // Masked path: mask 0F, i=A5 -> AA two cycles after the valid edge
    @(negedge clk); rst = 1'b0; #1;
    mask_wr = 1'b1; mask_in = 8'h0F; step();
    mask_wr = 1'b0; i8 = 8'hA5; in_valid = 1'b1; step();
    in_valid = 1'b0; i8 = 8'h00;
    check_eq("mask_lat1_qv", 16'(qv8), 16'h0000);
    step();
    check_eq("mask_q",       16'(q8),  16'h00AA);
    check_eq("mask_qv",      16'(qv8), 16'h0001);
    step();
    check_eq("mask_after_qv", 16'(qv8), 16'h0000);

    // Mask write on the same edge as a valid: data uses old mask FF
    do_reset();
    mask_wr = 1'b1; mask_in = 8'h00; i8 = 8'h3C; in_valid = 1'b1; step();
    mask_wr = 1'b0; step();
    check_eq("mtime_old_q",  16'(q8),  16'h00C3);
    check_eq("mtime_old_qv", 16'(qv8), 16'h0001);
    in_valid = 1'b0; step();
    check_eq("mtime_new_q",  16'(q8),  16'h003C);
    check_eq("mtime_new_qv", 16'(qv8), 16'h0001);
    step();
    check_eq("mtime_end_qv", 16'(qv8), 16'h0000);

    // Back-to-back valids under mask FF
    do_reset();
    in_valid = 1'b1; i8 = 8'h10; step();
    i8 = 8'h20; step();
    check_eq("b2b_q0", 16'(q8), 16'h00EF);
    i8 = 8'h30; step();
    check_eq("b2b_q1", 16'(q8), 16'h00DF);
    in_valid = 1'b0; step();
    check_eq("b2b_q2",  16'(q8),  16'h00CF);
    check_eq("b2b_qv2", 16'(qv8), 16'h0001);

    // Mid-stream reset: two valids in flight, reset clears outputs asynchronously
    do_reset();
    in_valid = 1'b1; i8 = 8'h11; step();
    i8 = 8'h22; step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_q",  16'(q8),  16'h0000);
    check_eq("mid_rst_qv", 16'(qv8), 16'h0000);
    @(negedge clk); rst = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("mid_rst_no_stale", 16'(qv8), 16'h0000);
    end

    // Release with in_valid high on the first edge: sample accepted
    @(negedge clk); rst = 1'b1; #2;
    @(negedge clk); rst = 1'b0; in_valid = 1'b1; i8 = 8'h55; #1;
    step();
    in_valid = 1'b0;
    check_eq("rel_lat1_qv", 16'(qv8), 16'h0000);
    step();
    check_eq("rel_q",  16'(q8),  16'h00AA);
    check_eq("rel_qv", 16'(qv8), 16'h0001);

    // Holding: one valid with i=01, then junk on i with in_valid low
    do_reset();
    in_valid = 1'b1; i8 = 8'h01; step();
    in_valid = 1'b0; i8 = 8'h77; step();
    check_eq("hold_first_q",  16'(q8),  16'h00FE);
    check_eq("hold_first_qv", 16'(qv8), 16'h0001);
    for (int k = 0; k < 4; k++) begin
      i8 = 8'(8'h40 + k);
      step();
      check_eq("hold_q",  16'(q8),  16'h00FE);
      check_eq("hold_qv", 16'(qv8), 16'h0000);
    end

`ifdef INVERTER_UNIT_TOGGLE_CNT_EN
    // Toggle counter: stream 00,00,FF,00 with mask 0 -> two changes
    do_reset();
    check_eq("tog_rst", tc8, 16'h0000);
    mask_wr = 1'b1; mask_in = 8'h00; step();
    mask_wr = 1'b0;
    in_valid = 1'b1; i8 = 8'h00; step();
    i8 = 8'h00; step();
    i8 = 8'hFF; step();
    i8 = 8'h00; step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_eq("tog_cnt", tc8, 16'h0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inverter_unit.md
Name: inverter_unit

Overview:
- Parameterised bit-wise inverter with a combinational path and a registered path.
- Combinational output o is the bit-wise NOT of input i and must propagate 4-state values: 0->1, 1->0, X->X, Z->X.
- Registered path adds per-bit invert masking, a valid qualifier and a fixed pipeline delay for timing-closed consumers.
- Used as a leaf polarity-correction cell between I/O pads and core logic.

Parameters:
- DATA_W, 1, width of i/o and all data paths.
- PIPE_STAGES, 1, register stages on the q path; legal range 1..4.
- MASK_RST, all-ones, reset value of the internal invert-mask register.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- i  input  DATA_W  data input.
- o  output  DATA_W  combinational ~i, no clock dependency.
- mask_wr  input  1  load mask_in into the invert-mask register.
- mask_in  input  DATA_W  new mask; bit=1 inverts, bit=0 passes through.
- in_valid  input  1  qualifies i for the registered path.
- q  output  DATA_W  registered (i XOR mask), delayed PIPE_STAGES cycles.
- q_valid  output  1  in_valid delayed PIPE_STAGES cycles.

Behaviour:
- o = ~i continuously, zero clock latency, independent of rst, mask and valid. X or Z on any i bit gives X on that o bit. No 2-state coercion on this path.
- Mask register:
  - Async reset to MASK_RST.
  - On a clk edge with mask_wr=1, loads mask_in.
  - The new mask affects data sampled on the following edge, not the same edge.
- Pipeline stage 0:
  - When in_valid=1, samples (i XOR mask).
  - When in_valid=0, holds its data; only the valid bit advances.
  - Each later stage copies the previous one every cycle.
  - q and q_valid come from the last stage.
- Latency:
  - Exactly PIPE_STAGES cycles from the in_valid edge to q_valid=1.
  - Back-to-back valids give back-to-back outputs. No backpressure.
- Reset:
  - Asynchronous; all pipeline data to 0, all valid bits to 0, mask to MASK_RST. o is unaffected.
  - q=0 and q_valid=0 during reset.
  - Reset asserted mid-stream discards all in-flight data. The first valid after release appears PIPE_STAGES cycles later.
- Simultaneous mask_wr and in_valid on the same edge: data uses the old mask.
- Reset release with in_valid=1 on the first edge: that sample is accepted normally.
- X on i with in_valid=1: q carries X in those bits. q_valid stays clean.

Optional Feature:
- Macro INVERTER_UNIT_TOGGLE_CNT_EN.
- With the macro defined:
  - Adds output toggle_cnt (16 bits).
  - Increments by 1 on each clk edge where q_valid=1 and q differs from the previous valid q.
  - Saturates at 16'hFFFF.
  - Async reset to 0.
  - The first valid after reset does not count.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package inverter_pkg holds:
  - PIPE_STAGES_MAX = 4.
  - TOGGLE_CNT_W = 16.
  - Typedef data_t sized by DATA_W through a parameterised localparam in the top level.
- One sub-module, inverter_pipe_stage: a single data+valid register with async reset, instantiated PIPE_STAGES times in a generate loop.

Test Plan:
- Combinational truth: DATA_W=1, i=0 then 1 then X then Z, checked 10 ns after each -> o=1, 0, X, X.
- Masked register path: DATA_W=8, PIPE_STAGES=2, mask 8'h0F, i=8'hA5 with in_valid pulse -> q=8'hAA and q_valid=1 exactly 2 cycles later.
- Mask timing: mask_wr with mask_in=8'h00 on the same edge as in_valid with i=8'h3C under reset mask FF -> q=8'hC3. The next valid with i=8'h3C -> q=8'h3C.
- Mid-stream reset: 2 valids in flight, pulse rst -> q=0 and q_valid=0 immediately (asynchronously). No stale valid appears after release.
- Holding: in_valid low for 5 cycles after a valid with i=8'h01 and mask FF -> q holds 8'hFE and q_valid=0 from cycle PIPE_STAGES+1 onward.
- Toggle counter (macro defined): valid stream 8'h00, 8'h00, 8'hFF, 8'h00 with mask 0 -> toggle_cnt=2.
